// File: rtl/bn_serial_slt.sv
// bn_serial_slt: bit-serial signed set-less-than (Z = X < Y), one full-adder slice, LSB first
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start, X, Y     request and operands, accepted only in IDLE
//   busy, done      high while bits are processed, one-cycle result-valid pulse
//   Z, V, D         X < Y (signed), signed overflow of X - Y, X - Y mod 2^N
module bn_serial_slt #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic         busy,
   output logic         done,
   output logic         Z,
   output logic         V,
   output logic [N-1:0] D
);
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
   state_t state, nxt;
   logic [N-1:0] xr, yr;
   logic [CW-1:0] cnt;
   logic c, yb, s, co, last;
   assign yb = ~yr[0];
   assign s = xr[0] ^ yb ^ c;
   assign co = (xr[0] & yb) | (xr[0] & c) | (yb & c);
   assign last = cnt == CW'(N - 1);
   always_comb begin
      nxt = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
            state == S_RUN  ? (last ? S_FIN : S_RUN) : S_IDLE;
      busy = state == S_RUN;
      done = state == S_FIN;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= nxt;
   // xr doubles as the difference shift register: each consumed X bit frees
   // the MSB slot for the new sum bit, so xr holds X - Y after N bits
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         xr <= '0;
         yr <= '0;
         c <= 1'b0;
         cnt <= '0;
         Z <= 1'b0;
         V <= 1'b0;
         D <= '0;
      end else if (state == S_IDLE && start) begin
         xr <= X;
         yr <= Y;
         c <= 1'b1;
         cnt <= '0;
      end else if (state == S_RUN) begin
         xr <= {s, xr[N-1:1]};
         yr <= yr >> 1;
         c <= co;
         cnt <= last ? cnt : cnt + 1'b1;
         if (last) begin
            D <= {s, xr[N-1:1]};
            V <= c ^ co;
            Z <= s ^ c ^ co;
         end
      end
endmodule

// File: tb/tb_bn_serial_slt.sv
// tb_bn_serial_slt: directed and randomized self-checking bench for bn_serial_slt (N=32)
module tb_bn_serial_slt;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [31:0] X = '0, Y = '0;
   logic busy, done, Z, V;
   logic [31:0] D;
   int tests = 0, fails = 0;

   bn_serial_slt #(.N(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
      .busy(busy), .done(done), .Z(Z), .V(V), .D(D)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // accept one operation, return edges from accept to done and busy cycle count
   task automatic op(input logic [31:0] x, y, output int lat, output int bcnt);
      @(negedge clk);
      X = x; Y = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic test_reset();
      #3;
      tests++; if ({busy, done, Z, V, D} !== 35'd0) begin fails++; $display("FAIL reset_outputs got %h exp 0", {busy, done, Z, V, D}); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_idle got %b exp 00", {busy, done}); end
   endtask

   task automatic test_basic();
      logic [31:0] tx [6] = '{32'd25, 32'd25, 32'hFFFFFFFB, 32'h7FFFFFFF, 32'h80000000, 32'd1234};
      logic [31:0] ty [6] = '{32'd5, 32'hFFFFFFFB, 32'd25, 32'h80000000, 32'h7FFFFFFF, 32'd1234};
      logic [31:0] td [6] = '{32'd20, 32'd30, 32'hFFFFFFE2, 32'hFFFFFFFF, 32'd1, 32'd0};
      logic tz [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic tv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int lat, bcnt;
      for (int i = 0; i < 6; i++) begin
         op(tx[i], ty[i], lat, bcnt);
         tests++; if (lat !== 32) begin fails++; $display("FAIL basic_latency[%0d] got %0d exp 32", i, lat); end
         tests++; if (bcnt !== 32) begin fails++; $display("FAIL basic_busy[%0d] got %0d exp 32", i, bcnt); end
         tests++; if (D !== td[i]) begin fails++; $display("FAIL basic_D[%0d] got %h exp %h", i, D, td[i]); end
         tests++; if (Z !== tz[i]) begin fails++; $display("FAIL basic_Z[%0d] got %b exp %b", i, Z, tz[i]); end
         tests++; if (V !== tv[i]) begin fails++; $display("FAIL basic_V[%0d] got %b exp %b", i, V, tv[i]); end
         @(posedge clk); #1;
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width[%0d] got %b exp 0", i, done); end
      end
   endtask

   task automatic test_ignore_start();
      int lat = 0, bcnt = 0;
      @(negedge clk);
      X = 32'd100; Y = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         if (lat == 10) begin
            tests++; if ({Z, V, D} !== 34'd0) begin fails++; $display("FAIL hold_during_run got %h exp 0", {Z, V, D}); end
         end
         if (lat == 3 || lat == 31) begin start = 1'b1; X = 32'h80000000; Y = 32'h00000009; end
         @(posedge clk);
         #1 start = 1'b0;
         lat++;
      end
      tests++; if (lat !== 32) begin fails++; $display("FAIL ignore_latency got %0d exp 32", lat); end
      tests++; if (bcnt !== 32) begin fails++; $display("FAIL ignore_busy got %0d exp 32", bcnt); end
      tests++; if ({Z, V, D} !== {2'b00, 32'd93}) begin fails++; $display("FAIL ignore_result got %h exp %h", {Z, V, D}, {2'b00, 32'd93}); end
      @(posedge clk); #1;
      tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL ignore_no_restart got %b exp 00", {busy, done}); end
      @(posedge clk); #1;
      tests++; if ({busy, done, D} !== {2'b00, 32'd93}) begin fails++; $display("FAIL ignore_idle_hold got %h exp %h", {busy, done, D}, {2'b00, 32'd93}); end
   endtask

   task automatic test_abort();
      int lat, bcnt, seen = 0;
      @(negedge clk);
      X = 32'd1; Y = 32'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      tests++; if ({busy, done, Z, V, D} !== 35'd0) begin fails++; $display("FAIL abort_clear got %h exp 0", {busy, done, Z, V, D}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin @(negedge clk); if (done || busy) seen++; end
      tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles exp 0", seen); end
      op(32'd5, 32'd25, lat, bcnt);
      tests++; if (lat !== 32) begin fails++; $display("FAIL abort_next_latency got %0d exp 32", lat); end
      tests++; if ({Z, V, D} !== {2'b10, 32'hFFFFFFEC}) begin fails++; $display("FAIL abort_next_result got %h exp %h", {Z, V, D}, {2'b10, 32'hFFFFFFEC}); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [31:0] sp [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      logic [31:0] x, y, ed;
      logic ez, ev;
      int lat, bcnt;
      for (int i = 0; i < 1000; i++) begin
         x = i < 16 ? sp[i / 4] : $urandom;
         y = i < 16 ? sp[i % 4] : $urandom;
         if (i >= 16 && i % 7 == 0) y = x;
         ed = x - y;
         ez = $signed(x) < $signed(y);
         ev = (x[31] ^ y[31]) & (ed[31] ^ x[31]);
         op(x, y, lat, bcnt);
         tests++; if (lat !== 32) begin fails++; $display("FAIL rand_latency[%0d] got %0d exp 32", i, lat); end
         tests++; if ({Z, V, D} !== {ez, ev, ed}) begin fails++; $display("FAIL rand_result[%0d] x=%h y=%h got %h exp %h", i, x, y, {Z, V, D}, {ez, ev, ed}); end
         @(posedge clk); #1;
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL rand_done_width[%0d] got %b exp 0", i, done); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
